// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and backend signals around the shared memory port
// Ports (all in the interface):
//   fetch   : if_req, if_addr -> if_done, if_rdata, if_stall
//   data    : dm_req, dm_wr, dm_addr, dm_wdata -> dm_done, dm_rdata, dm_stall
//   backend : mem_en, mem_wr, mem_addr, mem_wdata <- mem_done, mem_rdata
//   status  : err (sticky timeout)
// slave is the arbiter's view, master is the surrounding pipeline/backend view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        err;
    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
        output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );
    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_done, mem_rdata,
        input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between fetch and data accesses
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_port_arbiter_if.slave carrying requester handshakes, backend
//              command/response and the sticky timeout flag err
// Parameter TIMEOUT: WAIT cycles allowed before an access is aborted (2..255).
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state, state_n;
    logic       owner_d;
    logic [7:0] cnt;
    logic       grant_d, grant_i, finish, expire, close;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb
        state_n = (state == IDLE)  ? ((bus.dm_req || bus.if_req) ? ISSUE : IDLE) :
                  (state == ISSUE) ? WAIT :
                  (state == WAIT)  ? (close ? RESP : WAIT) : IDLE;

    // data wins simultaneous requests; a completion in the last WAIT cycle beats the timeout
    always_comb begin
        grant_d = state == IDLE && bus.dm_req;
        grant_i = state == IDLE && !bus.dm_req && bus.if_req;
        finish  = state == WAIT && bus.mem_done;
        expire  = state == WAIT && !bus.mem_done && cnt == 8'(TIMEOUT - 1);
        close   = finish || expire;
    end

    assign bus.if_stall = bus.if_req && !bus.if_done;
    assign bus.dm_stall = bus.dm_req && !bus.dm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d       <= 1'b0;
            cnt           <= 8'd0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= 16'h0;
            bus.mem_wdata <= 16'h0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.if_rdata  <= 16'h0;
            bus.dm_rdata  <= 16'h0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_en <= grant_d || grant_i;
            if (grant_d) begin
                owner_d       <= 1'b1;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wr    <= bus.dm_wr;
                bus.mem_wdata <= bus.dm_wdata;
            end else if (grant_i) begin
                owner_d       <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wr    <= 1'b0;
                bus.mem_wdata <= 16'h0;
            end
            cnt         <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            bus.dm_done <= close && owner_d;
            bus.if_done <= close && !owner_d;
            if (close && owner_d)
                bus.dm_rdata <= finish ? bus.mem_rdata : 16'h0;
            if (close && !owner_d)
                bus.if_rdata <= finish ? bus.mem_rdata : 16'h0;
            bus.err <= bus.err || expire;
        end
    end
endmodule
